cpu_trace_buffer: RTL and testbench



---
 rtl/cpu_trace_buffer_if.sv | 39 +++
 rtl/cpu_trace_buffer.sv | 172 +++++++++++++++++
 tb/tb_cpu_trace_buffer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_trace_buffer_if.sv
// Bundle of control, commit-capture and drain signals between the core-side
// producer and the commit-trace buffer.
interface cpu_trace_buffer_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 64
);
    localparam int REC_W = 3 * XLEN + 6;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             I_arm;
    logic             I_stop;
    logic [1:0]       I_mode;
    logic [XLEN-1:0]  I_trig_pc;
    logic             I_commit;
    logic [XLEN-1:0]  I_pc;
    logic [XLEN-1:0]  I_inst;
    logic [4:0]       I_rd;
    logic             I_regwen;
    logic [XLEN-1:0]  I_wbdata;
    logic             O_rd_valid;
    logic             I_rd_ready;
    logic [REC_W-1:0] O_rd_data;
    logic [1:0]       O_state;
    logic [CW-1:0]    O_count;
    logic             O_triggered;
    logic             O_overflow;

    modport slave (
        input  I_arm, I_stop, I_mode, I_trig_pc, I_commit, I_pc, I_inst,
               I_rd, I_regwen, I_wbdata, I_rd_ready,
        output O_rd_valid, O_rd_data, O_state, O_count, O_triggered, O_overflow
    );

    modport master (
        output I_arm, I_stop, I_mode, I_trig_pc, I_commit, I_pc, I_inst,
               I_rd, I_regwen, I_wbdata, I_rd_ready,
        input  O_rd_valid, O_rd_data, O_state, O_count, O_triggered, O_overflow
    );
endinterface

// File: rtl/cpu_trace_buffer.sv
// Commit-trace capture buffer: records retired instructions into a circular
// store (wrap / stop-on-full / PC-trigger modes) and drains them oldest-first.
module cpu_trace_buffer #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 64,
    parameter int POST_TRIG = 32
) (
    input  logic                I_clk,
    input  logic                I_rst,
    cpu_trace_buffer_if.slave   bus
);
    localparam int REC_W = 3 * XLEN + 6;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] POST_C  = CW'(POST_TRIG);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_POST    = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    rem_q, rem_d;
    logic             trig_q, trig_d;
    logic             ovf_q, ovf_d;
    logic [1:0]       mode_q, mode_d;
    logic [XLEN-1:0]  trig_pc_q, trig_pc_d;
    logic             we_s;
    logic             hs_s;
    logic             valid_s;
    logic [REC_W-1:0] rec_s;
    logic [REC_W-1:0] mem_q [DEPTH];

    assign rec_s   = {bus.I_pc, bus.I_inst, bus.I_rd, bus.I_regwen, bus.I_wbdata};
    assign valid_s = (state_q == ST_DONE) && (count_q != {CW{1'b0}});
    assign hs_s    = valid_s && bus.I_rd_ready;

    // Control and pointer state; records are lost on reset.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q   <= ST_IDLE;
            wptr_q    <= {AW{1'b0}};
            rptr_q    <= {AW{1'b0}};
            count_q   <= {CW{1'b0}};
            rem_q     <= {CW{1'b0}};
            trig_q    <= 1'b0;
            ovf_q     <= 1'b0;
            mode_q    <= 2'b00;
            trig_pc_q <= {XLEN{1'b0}};
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            trig_q    <= trig_d;
            ovf_q     <= ovf_d;
            mode_q    <= mode_d;
            trig_pc_q <= trig_pc_d;
        end
    end

    // Record storage; contents deliberately not reset.
    always_ff @(posedge I_clk) begin
        if (we_s) begin
            mem_q[wptr_q] <= rec_s;
        end
    end

    // Next-state: arm dominates stop, trigger and read handshakes.
    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        rem_d     = rem_q;
        trig_d    = trig_q;
        ovf_d     = ovf_q;
        mode_d    = mode_q;
        trig_pc_d = trig_pc_q;
        we_s      = 1'b0;

        if (bus.I_arm) begin
            state_d   = ST_CAPTURE;
            wptr_d    = {AW{1'b0}};
            rptr_d    = {AW{1'b0}};
            count_d   = {CW{1'b0}};
            rem_d     = {CW{1'b0}};
            trig_d    = 1'b0;
            ovf_d     = 1'b0;
            mode_d    = bus.I_mode;
            trig_pc_d = bus.I_trig_pc;
        end else begin
            case (state_q)
                ST_CAPTURE, ST_POST: begin
                    if (bus.I_commit) begin
                        we_s   = 1'b1;
                        wptr_d = wptr_q + AW'(1);
                        if (count_q < DEPTH_C) begin
                            count_d = count_q + CW'(1);
                        end else begin
                            rptr_d = rptr_q + AW'(1);
                            ovf_d  = 1'b1;
                        end
                        if (state_q == ST_CAPTURE) begin
                            if (mode_q == 2'b01) begin
                                if (count_q == DEPTH_C - CW'(1)) begin
                                    state_d = ST_DONE;
                                end else begin
                                    state_d = ST_CAPTURE;
                                end
                            end else if ((mode_q == 2'b10) && (bus.I_pc == trig_pc_q)) begin
                                trig_d = 1'b1;
                                if (POST_C == {CW{1'b0}}) begin
                                    state_d = ST_DONE;
                                end else begin
                                    state_d = ST_POST;
                                    rem_d   = POST_C;
                                end
                            end else begin
                                state_d = ST_CAPTURE;
                            end
                        end else begin
                            // POST: the trigger PC is not compared here any more.
                            rem_d = rem_q - CW'(1);
                            if (rem_q == CW'(1)) begin
                                state_d = ST_DONE;
                            end else begin
                                state_d = ST_POST;
                            end
                        end
                    end else begin
                        we_s = 1'b0;
                    end
                    if (bus.I_stop) begin
                        state_d = ST_DONE;
                    end else begin
                        we_s = we_s;
                    end
                end
                ST_DONE: begin
                    if (hs_s) begin
                        rptr_d  = rptr_q + AW'(1);
                        count_d = count_q - CW'(1);
                    end else begin
                        rptr_d = rptr_q;
                    end
                end
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.O_state     = state_q;
    assign bus.O_count     = count_q;
    assign bus.O_triggered = trig_q;
    assign bus.O_overflow  = ovf_q;
    assign bus.O_rd_valid  = valid_s;
    assign bus.O_rd_data   = mem_q[rptr_q];

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Scoreboard bench for cpu_trace_buffer (DEPTH=8, POST_TRIG=2): a bench-side
// capture model queues expected records, the drain pops and compares them.
module tb_cpu_trace_buffer;
    localparam int XLEN  = 32;
    localparam int DEPTH = 8;
    localparam int REC_W = 3 * XLEN + 6;

    logic I_clk = 1'b0;
    logic I_rst = 1'b1;

    cpu_trace_buffer_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    cpu_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(2)) dut (
        .I_clk (I_clk),
        .I_rst (I_rst),
        .bus   (bus)
    );

    always #5 I_clk = ~I_clk;

    int n_vec = 0;
    int n_err = 0;

    logic [REC_W-1:0] sb [$];
    int               m_state;
    logic [1:0]       m_mode;
    logic [31:0]      m_trig_pc;
    int               m_rem;
    bit               m_trg;
    bit               m_ovf;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [REC_W-1:0] mk_rec(input logic [31:0] pc);
        return {pc, pc ^ 32'h0013_0093, pc[6:2], pc[2], ~pc};
    endfunction

    task automatic chk_model(input string tag);
        chk({tag, "_state"}, 128'(bus.O_state), 128'(m_state));
        chk({tag, "_count"}, 128'(bus.O_count), 128'(sb.size()));
        chk({tag, "_trig"},  128'(bus.O_triggered), 128'(m_trg));
        chk({tag, "_ovf"},   128'(bus.O_overflow), 128'(m_ovf));
    endtask

    task automatic arm(input logic [1:0] mode, input logic [31:0] tpc);
        @(negedge I_clk);
        bus.I_arm     = 1'b1;
        bus.I_mode    = mode;
        bus.I_trig_pc = tpc;
        bus.I_commit  = 1'b1;
        bus.I_pc      = tpc;
        @(negedge I_clk);
        bus.I_arm    = 1'b0;
        bus.I_commit = 1'b0;
        bus.I_rd_ready = 1'b0;
        sb.delete();
        m_state   = 1;
        m_mode    = mode;
        m_trig_pc = tpc;
        m_rem     = 0;
        m_trg     = 1'b0;
        m_ovf     = 1'b0;
        chk_model("arm");
        chk("arm_valid", 128'(bus.O_rd_valid), 128'(0));
    endtask

    task automatic commit(input logic [31:0] pc);
        @(negedge I_clk);
        chk_model("cap");
        bus.I_commit = 1'b1;
        bus.I_pc     = pc;
        {bus.I_pc, bus.I_inst, bus.I_rd, bus.I_regwen, bus.I_wbdata} = mk_rec(pc);
        if (m_state == 1 || m_state == 2) begin
            sb.push_back(mk_rec(pc));
            if (sb.size() > DEPTH) begin
                void'(sb.pop_front());
                m_ovf = 1'b1;
            end
            if (m_state == 1) begin
                if (m_mode == 2'b01 && sb.size() == DEPTH) m_state = 3;
                else if (m_mode == 2'b10 && pc == m_trig_pc) begin
                    m_trg   = 1'b1;
                    m_rem   = 2;
                    m_state = 2;
                end
            end else begin
                m_rem--;
                if (m_rem == 0) m_state = 3;
            end
        end
    endtask

    task automatic idle();
        @(negedge I_clk);
        chk_model("idle");
        bus.I_commit = 1'b0;
        bus.I_stop   = 1'b0;
    endtask

    task automatic stop();
        @(negedge I_clk);
        bus.I_commit = 1'b0;
        bus.I_stop   = 1'b1;
        if (m_state == 1 || m_state == 2) m_state = 3;
        @(negedge I_clk);
        bus.I_stop = 1'b0;
        chk_model("stop");
    endtask

    task automatic drain(input bit toggle);
        int cyc = 0;
        bit rdy;
        while (sb.size() > 0 && cyc < 200) begin
            if (cyc > 0) @(negedge I_clk);
            chk("drain_valid", 128'(bus.O_rd_valid), 128'(1));
            chk("drain_data", 128'(bus.O_rd_data), 128'(sb[0]));
            rdy = toggle ? (cyc % 2 == 0) : 1'b1;
            bus.I_rd_ready = rdy;
            if (rdy) void'(sb.pop_front());
            cyc++;
        end
        chk("drain_bound", 128'(sb.size()), 128'(0));
        @(negedge I_clk);
        bus.I_rd_ready = 1'b0;
        chk("drain_empty_valid", 128'(bus.O_rd_valid), 128'(0));
        chk("drain_empty_count", 128'(bus.O_count), 128'(0));
        chk("drain_state", 128'(bus.O_state), 128'(3));
    endtask

    initial begin
        bus.I_arm = 1'b0; bus.I_stop = 1'b0; bus.I_mode = 2'b00; bus.I_trig_pc = '0;
        bus.I_commit = 1'b0; bus.I_pc = '0; bus.I_inst = '0; bus.I_rd = 5'd0;
        bus.I_regwen = 1'b0; bus.I_wbdata = '0; bus.I_rd_ready = 1'b0;
        m_state = 0; m_mode = 2'b00; m_trig_pc = '0; m_rem = 0; m_trg = 1'b0; m_ovf = 1'b0;
        repeat (2) @(negedge I_clk);
        chk_model("reset");
        chk("reset_valid", 128'(bus.O_rd_valid), 128'(0));
        I_rst = 1'b0;
        idle();

        // Wrap mode, short run.
        arm(2'b00, 32'h0);
        for (int i = 0; i < 5; i++) commit(32'(i * 4));
        stop();
        drain(1'b0);

        // Wrap mode with overwrite.
        arm(2'b11, 32'h0);
        for (int i = 0; i < 11; i++) commit(32'(i * 4));
        stop();
        drain(1'b0);

        // Stop-on-full.
        arm(2'b01, 32'h0);
        for (int i = 0; i < 10; i++) commit(32'(i * 4));
        idle();
        drain(1'b0);

        // PC trigger with post-trigger depth.
        arm(2'b10, 32'h14);
        for (int i = 0; i < 13; i++) commit(32'(i * 4));
        idle();
        drain(1'b1);

        // Arm in the middle of a drain.
        arm(2'b00, 32'h0);
        for (int i = 0; i < 4; i++) commit(32'h40 + 32'(i * 4));
        stop();
        chk("mid_data0", 128'(bus.O_rd_data), 128'(sb[0]));
        bus.I_rd_ready = 1'b1;
        void'(sb.pop_front());
        @(negedge I_clk);
        chk("mid_data1", 128'(bus.O_rd_data), 128'(sb[0]));
        arm(2'b00, 32'h0);

        // Asynchronous reset during POST.
        arm(2'b10, 32'h08);
        for (int i = 0; i < 3; i++) commit(32'(i * 4));
        idle();
        #2 I_rst = 1'b1;
        #1;
        chk("async_state", 128'(bus.O_state), 128'(0));
        chk("async_count", 128'(bus.O_count), 128'(0));
        @(negedge I_clk);
        I_rst = 1'b0;
        sb.delete();
        m_state = 0; m_trg = 1'b0; m_ovf = 1'b0;
        idle();
        arm(2'b00, 32'h0);
        for (int i = 0; i < 3; i++) commit(32'h100 + 32'(i * 4));
        stop();
        drain(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
